// File: rtl/reg_alu_pipe.sv
// Register file + 8-op ALU with one execute/writeback stage, operand forwarding and
// carry/zero/negative flag registers. Reset is synchronous and active-high.
module reg_alu_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREGS = 8,
   localparam int unsigned AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic             sel,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out_a,
   output logic [WIDTH-1:0] d_out_b,
   output logic             cout,
   output logic             zero,
   output logic             neg
);

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001,
      OpAnd = 3'b010,
      OpOr  = 3'b011,
      OpXor = 3'b100,
      OpAdc = 3'b101,
      OpShl = 3'b110,
      OpShr = 3'b111
   } op_e;

   logic [WIDTH-1:0] rf_q [NREGS];

   logic             stg_valid_q, stg_valid_d;
   logic             stg_sel_q, stg_sel_d;
   logic [AW-1:0]    stg_addr_q, stg_addr_d;
   logic [WIDTH-1:0] stg_data_q, stg_data_d;
   logic             stg_c_q, stg_c_d;
   logic             stg_z_q, stg_z_d;
   logic             stg_n_q, stg_n_d;

   logic             cout_q, zero_q, neg_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             cf;

   // The stage holds the youngest write, so it overrides the file on an address match.
   always_comb begin
      d_out_a = rf_q[rd_addr_a];
      d_out_b = rf_q[rd_addr_b];
      if (stg_valid_q && (stg_addr_q == rd_addr_a)) d_out_a = stg_data_q;
      if (stg_valid_q && (stg_addr_q == rd_addr_b)) d_out_b = stg_data_q;
   end

   assign cf = (stg_valid_q && stg_sel_q) ? stg_c_q : cout_q;

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_e'(op))
         OpAdd: begin
            sum     = {1'b0, d_out_a} + {1'b0, d_out_b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OpSub: begin
            // The extra MSB of the difference is the borrow (A < B unsigned).
            sum     = {1'b0, d_out_a} - {1'b0, d_out_b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OpAnd: alu_res = d_out_a & d_out_b;
         OpOr:  alu_res = d_out_a | d_out_b;
         OpXor: alu_res = d_out_a ^ d_out_b;
         OpAdc: begin
            sum     = {1'b0, d_out_a} + {1'b0, d_out_b} + {{WIDTH{1'b0}}, cf};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OpShl: begin
            alu_res = {d_out_a[WIDTH-2:0], 1'b0};
            alu_c   = d_out_a[WIDTH-1];
         end
         OpShr: begin
            alu_res = {1'b0, d_out_a[WIDTH-1:1]};
            alu_c   = d_out_a[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      stg_valid_d = wr;
      stg_sel_d   = sel;
      stg_addr_d  = wr_addr;
      stg_data_d  = sel ? alu_res : d_in;
      stg_c_d     = alu_c;
      stg_z_d     = (alu_res == '0);
      stg_n_d     = alu_res[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
         stg_valid_q <= 1'b0;
         stg_sel_q   <= 1'b0;
         stg_addr_q  <= '0;
         stg_data_q  <= '0;
         stg_c_q     <= 1'b0;
         stg_z_q     <= 1'b0;
         stg_n_q     <= 1'b0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
      end else begin
         stg_valid_q <= stg_valid_d;
         stg_sel_q   <= stg_sel_d;
         stg_addr_q  <= stg_addr_d;
         stg_data_q  <= stg_data_d;
         stg_c_q     <= stg_c_d;
         stg_z_q     <= stg_z_d;
         stg_n_q     <= stg_n_d;
         if (stg_valid_q) begin
            rf_q[stg_addr_q] <= stg_data_q;
            // External loads leave the flags untouched.
            if (stg_sel_q) begin
               cout_q <= stg_c_q;
               zero_q <= stg_z_q;
               neg_q  <= stg_n_q;
            end
         end
      end
   end

   assign cout = cout_q;
   assign zero = zero_q;
   assign neg  = neg_q;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed bench for reg_alu_pipe: architectural register/flag model plus a scoreboard of
// in-flight writes whose flags become visible two cycles after issue.
module tb_reg_alu_pipe;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAdc = 3'b101;
   localparam logic [2:0] OpShl = 3'b110;
   localparam logic [2:0] OpShr = 3'b111;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Default instance: WIDTH=16, NREGS=8
   logic        wr, sel;
   logic [2:0]  op, ra, rb, wa;
   logic [15:0] din, da, db;
   logic        co, ze, ne;

   // WIDTH=8, NREGS=4
   logic        w8, s8;
   logic [2:0]  op8;
   logic [1:0]  ra8, rb8, wa8;
   logic [7:0]  din8, da8, db8;
   logic        co8, ze8, ne8;

   // WIDTH=32, NREGS=16
   logic        w32, s32;
   logic [2:0]  op32;
   logic [3:0]  ra32, rb32, wa32;
   logic [31:0] din32, da32, db32;
   logic        co32, ze32, ne32;

   reg_alu_pipe dut (
      .clk(clk), .reset(reset), .wr(wr), .sel(sel), .op(op),
      .rd_addr_a(ra), .rd_addr_b(rb), .wr_addr(wa), .d_in(din),
      .d_out_a(da), .d_out_b(db), .cout(co), .zero(ze), .neg(ne)
   );

   reg_alu_pipe #(.WIDTH(8), .NREGS(4)) dut8 (
      .clk(clk), .reset(reset), .wr(w8), .sel(s8), .op(op8),
      .rd_addr_a(ra8), .rd_addr_b(rb8), .wr_addr(wa8), .d_in(din8),
      .d_out_a(da8), .d_out_b(db8), .cout(co8), .zero(ze8), .neg(ne8)
   );

   reg_alu_pipe #(.WIDTH(32), .NREGS(16)) dut32 (
      .clk(clk), .reset(reset), .wr(w32), .sel(s32), .op(op32),
      .rd_addr_a(ra32), .rd_addr_b(rb32), .wr_addr(wa32), .d_in(din32),
      .d_out_a(da32), .d_out_b(db32), .cout(co32), .zero(ze32), .neg(ne32)
   );

   typedef struct {
      int   due;
      logic sel;
      logic c;
      logic z;
      logic n;
   } ent_t;

   ent_t        sb[$];
   logic [31:0] q32[$];
   logic [31:0] exp32 [16];
   logic [15:0] m_regs [8];
   logic        m_cf, m_c, m_z, m_n;
   int          cyc;
   int          checks;
   int          errors;
   logic [15:0] obs_a, obs_b;
   logic        obs_c, obs_z, obs_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_alu(input logic [2:0] o, input logic [15:0] a,
                                     input logic [15:0] b, input logic ci,
                                     output logic [15:0] r, output logic c);
      logic [16:0] t;
      r = '0;
      c = 1'b0;
      case (o)
         3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16]; end
         3'd1: begin r = a - b; c = (a < b); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin t = {1'b0, a} + {1'b0, b} + {16'd0, ci}; r = t[15:0]; c = t[16]; end
         3'd6: begin r = a << 1; c = a[15]; end
         default: begin r = a >> 1; c = a[0]; end
      endcase
   endfunction

   task automatic rst_step();
      reset = 1'b1;
      wr    = 1'b0;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_cf = 1'b0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One cycle on the default instance; called just after a falling edge.
   task automatic step(input logic w, input logic s, input logic [2:0] o,
                       input logic [2:0] a_addr, input logic [2:0] b_addr,
                       input logic [2:0] w_addr, input logic [15:0] data);
      ent_t        e;
      logic [15:0] r;
      logic        c;
      wr = w; sel = s; op = o; ra = a_addr; rb = b_addr; wa = w_addr; din = data;
      #1;
      obs_a = da; obs_b = db; obs_c = co; obs_z = ze; obs_n = ne;
      chk("d_out_a", {16'd0, da}, {16'd0, m_regs[a_addr]});
      chk("d_out_b", {16'd0, db}, {16'd0, m_regs[b_addr]});
      chk("cout", {31'd0, co}, {31'd0, m_c});
      chk("zero", {31'd0, ze}, {31'd0, m_z});
      chk("neg", {31'd0, ne}, {31'd0, m_n});
      if (w) begin
         c = 1'b0;
         if (s) begin
            model_alu(o, m_regs[a_addr], m_regs[b_addr], m_cf, r, c);
            m_cf = c;
         end else begin
            r = data;
         end
         e.due = cyc + 2; e.sel = s; e.c = c; e.z = (r == 16'd0); e.n = r[15];
         sb.push_back(e);
         m_regs[w_addr] = r;
      end
      @(posedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.sel) begin
            m_c = e.c; m_z = e.z; m_n = e.n;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0;
      reset = 1'b1;
      wr = 0; sel = 0; op = 0; ra = 0; rb = 0; wa = 0; din = 0;
      w8 = 0; s8 = 0; op8 = 0; ra8 = 0; rb8 = 0; wa8 = 0; din8 = 0;
      w32 = 0; s32 = 0; op32 = 0; ra32 = 0; rb32 = 0; wa32 = 0; din32 = 0;
      @(negedge clk);
      rst_step();

      // Reset state and loads
      step(0, 0, 0, 1, 2, 0, 16'h0);
      chk("rst_r1", {16'd0, obs_a}, 32'h0);
      step(1, 0, 0, 1, 2, 1, 16'h0005);
      step(1, 0, 0, 1, 2, 2, 16'h0003);
      chk("ld_r1_fwd", {16'd0, obs_a}, 32'h0005);
      // ALU with forwarding
      step(1, 1, OpAdd, 1, 2, 3, 16'h0);
      chk("ld_r2_fwd", {16'd0, obs_b}, 32'h0003);
      step(1, 1, OpSub, 3, 2, 4, 16'h0);
      chk("add_r3_fwd", {16'd0, obs_a}, 32'h0008);
      step(0, 0, 0, 4, 3, 0, 16'h0);
      chk("sub_r4", {16'd0, obs_a}, 32'h0005);
      chk("r3_file", {16'd0, obs_b}, 32'h0008);
      step(0, 0, 0, 4, 3, 0, 16'h0);
      chk("sub_cout", {31'd0, obs_c}, 32'h0);

      // Carry chain
      step(1, 0, 0, 0, 0, 1, 16'hFFFF);
      step(1, 0, 0, 0, 0, 2, 16'h0001);
      step(1, 1, OpAdd, 1, 2, 5, 16'h0);
      step(1, 1, OpAdc, 2, 2, 6, 16'h0);
      step(0, 0, 0, 5, 6, 0, 16'h0);
      chk("add_r5", {16'd0, obs_a}, 32'h0000);
      chk("adc_r6", {16'd0, obs_b}, 32'h0003);
      chk("add_cout", {31'd0, obs_c}, 32'h1);
      chk("add_zero", {31'd0, obs_z}, 32'h1);
      step(0, 0, 0, 5, 6, 0, 16'h0);
      chk("adc_cout", {31'd0, obs_c}, 32'h0);
      chk("adc_zero", {31'd0, obs_z}, 32'h0);

      // Borrow and shifts
      step(1, 0, 0, 0, 0, 1, 16'h0003);
      step(1, 0, 0, 0, 0, 2, 16'h0005);
      step(1, 1, OpSub, 1, 2, 3, 16'h0);
      step(0, 0, 0, 3, 3, 0, 16'h0);
      chk("sub_neg_a", {16'd0, obs_a}, 32'hFFFE);
      chk("sub_neg_b", {16'd0, obs_b}, 32'hFFFE);
      step(1, 0, 0, 3, 3, 1, 16'h8001);
      chk("borrow", {31'd0, obs_c}, 32'h1);
      chk("borrow_neg", {31'd0, obs_n}, 32'h1);
      step(1, 1, OpShl, 1, 0, 4, 16'h0);
      step(1, 0, 0, 4, 0, 1, 16'h0003);
      chk("shl_r4", {16'd0, obs_a}, 32'h0002);
      step(1, 1, OpShr, 1, 0, 4, 16'h0);
      chk("shl_cout", {31'd0, obs_c}, 32'h1);
      chk("shl_neg", {31'd0, obs_n}, 32'h0);
      step(0, 0, 0, 4, 0, 0, 16'h0);
      chk("shr_r4", {16'd0, obs_a}, 32'h0001);
      step(0, 0, 0, 4, 0, 0, 16'h0);
      chk("shr_cout", {31'd0, obs_c}, 32'h1);

      // Younger write to the same address wins; loads leave flags alone
      step(1, 0, 0, 0, 0, 0, 16'hAAAA);
      step(1, 0, 0, 0, 0, 0, 16'h5555);
      step(0, 0, 0, 0, 0, 0, 16'h0);
      chk("waw_fwd", {16'd0, obs_a}, 32'h5555);
      step(0, 0, 0, 0, 0, 0, 16'h0);
      chk("waw_file", {16'd0, obs_b}, 32'h5555);
      chk("load_keeps_cout", {31'd0, obs_c}, 32'h1);

      // Reset while a load is in the stage
      step(1, 0, 0, 7, 7, 7, 16'h1234);
      ra = 3'd7;
      rst_step();
      step(0, 0, 0, 7, 7, 0, 16'h0);
      chk("rst_drop_r7", {16'd0, obs_a}, 32'h0);
      chk("rst_cout", {31'd0, obs_c}, 32'h0);
      step(0, 0, 0, 7, 7, 0, 16'h0);
      chk("rst_drop_r7_file", {16'd0, obs_a}, 32'h0);

      // WIDTH=8, NREGS=4: 0xFF + 0x01
      w8 = 1; s8 = 0; wa8 = 2'd1; din8 = 8'hFF;
      @(negedge clk);
      wa8 = 2'd2; din8 = 8'h01;
      @(negedge clk);
      s8 = 1; op8 = OpAdd; ra8 = 2'd1; rb8 = 2'd2; wa8 = 2'd3;
      @(negedge clk);
      w8 = 0; ra8 = 2'd3;
      #1;
      chk("w8_add_res", {24'd0, da8}, 32'h00);
      @(negedge clk);
      #1;
      chk("w8_add_cout", {31'd0, co8}, 32'h1);
      chk("w8_add_zero", {31'd0, ze8}, 32'h1);
      chk("w8_file_res", {24'd0, da8}, 32'h00);

      // WIDTH=32, NREGS=16: fill every register with a unique value
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         w32 = 1; s32 = 0; wa32 = 4'(i);
         din32 = 32'hC0DE_0000 + 32'(i) * 32'h0101_0101 + 32'(i);
         exp32[i] = din32;
         q32.push_back(din32);
         @(negedge clk);
      end
      w32 = 0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         logic [31:0] e32;
         ra32 = 4'(i);
         rb32 = 4'(15 - i);
         #1;
         e32 = q32.pop_front();
         chk("w32_port_a", da32, e32);
         chk("w32_port_b", db32, exp32[15 - i]);
         @(negedge clk);
      end
      chk("w32_flags", {29'd0, co32, ze32, ne32}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
